// File: rtl/ram_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ram_pkg : shared sizes and helpers for the result RAM            |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package ram_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 4;
  localparam int BANK_WORDS = 8;
  localparam int ARIT_BASE  = 8;
  localparam int LOGIC_BASE = 0;
  localparam int IDX_W      = 3;
  localparam int CNT_W      = 4;

  typedef enum logic {
    BANK_LOGIC = 1'b0,
    BANK_ARIT  = 1'b1
  } bank_e;

  function automatic logic [CNT_W-1:0] popcnt(input logic [BANK_WORDS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < BANK_WORDS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bank_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bank_tracker : valid bits, occupancy count and status of a bank  |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module bank_tracker
  import ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_set_en,
  input  logic [IDX_W-1:0]      i_set_idx,
  input  logic                  i_clr_en,
  input  logic [IDX_W-1:0]      i_clr_idx,
  output logic [BANK_WORDS-1:0] o_valid,
  output logic [CNT_W-1:0]      o_cnt,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [BANK_WORDS-1:0] r_valid;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_full;
  logic                  r_empty;

  logic [BANK_WORDS-1:0] w_set_mask;
  logic [BANK_WORDS-1:0] w_clr_mask;
  logic [BANK_WORDS-1:0] w_valid_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;

  // Clear dominates so a same-word write+read leaves the word consumed.
  always_comb begin
    w_set_mask  = i_set_en ? (BANK_WORDS'(1) << i_set_idx) : '0;
    w_clr_mask  = i_clr_en ? (BANK_WORDS'(1) << i_clr_idx) : '0;
    w_valid_nxt = (r_valid | w_set_mask) & ~w_clr_mask;
    w_cnt_nxt   = popcnt(w_valid_nxt);
  end

  // Count and flags derive from the next valid vector, so all three stay coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_valid <= w_valid_nxt;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CNT_W'(BANK_WORDS));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  assign o_valid = r_valid;
  assign o_cnt   = r_cnt;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/result_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | result_ram : two-bank consume-on-read result store with status   |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module result_ram #(
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int ADDR_W = ram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [DATA_W-1:0] d_in,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] addr_r,
  output logic [DATA_W-1:0] d_out,
  output logic              d_valid,
  output logic              w_ack,
  output logic [3:0]        cnt_arit,
  output logic [3:0]        cnt_logic,
  output logic              full_arit,
  output logic              full_logic,
  output logic              empty_arit,
  output logic              empty_logic,
  output logic              ovr_err,
  output logic              udr_err
);

  localparam int c_WORDS = 2 ** ADDR_W;
  localparam int c_BW    = ram_pkg::BANK_WORDS;
  localparam int c_IW    = ram_pkg::IDX_W;

  logic [DATA_W-1:0] r_mem [c_WORDS];
  logic [DATA_W-1:0] r_d_out;
  logic              r_d_valid;
  logic              r_w_ack;
  logic              r_ovr;
  logic              r_udr;

  logic [c_BW-1:0]   w_valid_logic;
  logic [c_BW-1:0]   w_valid_arit;
  logic              w_wr_bank;
  logic              w_rd_bank;
  logic [c_IW-1:0]   w_wr_idx;
  logic [c_IW-1:0]   w_rd_idx;
  logic              w_wr_valid;
  logic              w_rd_valid;
  logic              w_same;
  logic              w_consume;

  always_comb begin
    w_wr_bank  = addr_w[c_IW];
    w_rd_bank  = addr_r[c_IW];
    w_wr_idx   = addr_w[c_IW-1:0];
    w_rd_idx   = addr_r[c_IW-1:0];
    w_wr_valid = (w_wr_bank == ram_pkg::BANK_ARIT) ? w_valid_arit[w_wr_idx]
                                                   : w_valid_logic[w_wr_idx];
    w_rd_valid = (w_rd_bank == ram_pkg::BANK_ARIT) ? w_valid_arit[w_rd_idx]
                                                   : w_valid_logic[w_rd_idx];
    w_same     = w_en && r_en && (addr_w == addr_r);
    w_consume  = r_en && (w_rd_valid || w_same);
  end

  bank_tracker u_logic (
    .clk       (clk),
    .rst       (rst),
    .i_set_en  (w_en && (w_wr_bank == ram_pkg::BANK_LOGIC)),
    .i_set_idx (w_wr_idx),
    .i_clr_en  (w_consume && (w_rd_bank == ram_pkg::BANK_LOGIC)),
    .i_clr_idx (w_rd_idx),
    .o_valid   (w_valid_logic),
    .o_cnt     (cnt_logic),
    .o_full    (full_logic),
    .o_empty   (empty_logic)
  );

  bank_tracker u_arit (
    .clk       (clk),
    .rst       (rst),
    .i_set_en  (w_en && (w_wr_bank == ram_pkg::BANK_ARIT)),
    .i_set_idx (w_wr_idx),
    .i_clr_en  (w_consume && (w_rd_bank == ram_pkg::BANK_ARIT)),
    .i_clr_idx (w_rd_idx),
    .o_valid   (w_valid_arit),
    .o_cnt     (cnt_arit),
    .o_full    (full_arit),
    .o_empty   (empty_arit)
  );

  always_ff @(posedge clk) begin
    if (w_en && !rst) begin
      r_mem[addr_w] <= d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_out   <= '0;
      r_d_valid <= 1'b0;
      r_w_ack   <= 1'b0;
      r_ovr     <= 1'b0;
      r_udr     <= 1'b0;
    end else begin
      r_w_ack   <= w_en;
      r_d_valid <= 1'b0;
      if (w_en && w_wr_valid && !w_same) begin
        r_ovr <= 1'b1;
      end
      if (r_en) begin
        if (w_same) begin
          r_d_out   <= d_in;
          r_d_valid <= 1'b1;
        end else if (w_rd_valid) begin
          r_d_out   <= r_mem[addr_r];
          r_d_valid <= 1'b1;
        end else begin
          r_d_out <= '0;
          r_udr   <= 1'b1;
        end
      end
    end
  end

  // Pulses already registered when rst rises are suppressed immediately.
  assign w_ack   = r_w_ack & ~rst;
  assign d_valid = r_d_valid & ~rst;
  assign d_out   = r_d_out;
  assign ovr_err = r_ovr;
  assign udr_err = r_udr;

endmodule
`default_nettype wire

// File: tb/tb_result_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_result_ram : directed self-checking bench for result_ram      |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_result_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_en = 1'b0;
  logic [3:0]  addr_w = '0;
  logic [31:0] d_in = '0;
  logic        r_en = 1'b0;
  logic [3:0]  addr_r = '0;
  logic [31:0] d_out;
  logic        d_valid;
  logic        w_ack;
  logic [3:0]  cnt_arit;
  logic [3:0]  cnt_logic;
  logic        full_arit;
  logic        full_logic;
  logic        empty_arit;
  logic        empty_logic;
  logic        ovr_err;
  logic        udr_err;

  int vectors = 0;
  int miscompares = 0;

  result_ram #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .w_en        (w_en),
    .addr_w      (addr_w),
    .d_in        (d_in),
    .r_en        (r_en),
    .addr_r      (addr_r),
    .d_out       (d_out),
    .d_valid     (d_valid),
    .w_ack       (w_ack),
    .cnt_arit    (cnt_arit),
    .cnt_logic   (cnt_logic),
    .full_arit   (full_arit),
    .full_logic  (full_logic),
    .empty_arit  (empty_arit),
    .empty_logic (empty_logic),
    .ovr_err     (ovr_err),
    .udr_err     (udr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_cnt_arit", 32'(cnt_arit), 32'd0);
    chk("rst_cnt_logic", 32'(cnt_logic), 32'd0);
    chk("rst_empty_arit", 32'(empty_arit), 32'd1);
    chk("rst_empty_logic", 32'(empty_logic), 32'd1);
    chk("rst_full", 32'({full_arit, full_logic}), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_w_ack", 32'(w_ack), 32'd0);
    chk("rst_d_out", d_out, 32'd0);
    chk("rst_errs", 32'({ovr_err, udr_err}), 32'd0);

    // Write 9 then read 9
    w_en = 1'b1; addr_w = 4'd9; d_in = 32'hDEAD_BEEF;
    tick();
    idle();
    chk("wr9_w_ack", 32'(w_ack), 32'd1);
    chk("wr9_cnt_arit", 32'(cnt_arit), 32'd1);
    chk("wr9_empty_arit", 32'(empty_arit), 32'd0);
    chk("wr9_cnt_logic", 32'(cnt_logic), 32'd0);
    r_en = 1'b1; addr_r = 4'd9;
    tick();
    idle();
    chk("rd9_d_valid", 32'(d_valid), 32'd1);
    chk("rd9_d_out", d_out, 32'hDEAD_BEEF);
    chk("rd9_w_ack", 32'(w_ack), 32'd0);
    chk("rd9_cnt_arit", 32'(cnt_arit), 32'd0);
    chk("rd9_empty_arit", 32'(empty_arit), 32'd1);
    tick();
    chk("hold_d_valid", 32'(d_valid), 32'd0);
    chk("hold_d_out", d_out, 32'hDEAD_BEEF);

    // Fill logic bank
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; addr_w = 4'(i); d_in = 32'h100 + 32'(i);
      tick();
    end
    idle();
    chk("fill_cnt_logic", 32'(cnt_logic), 32'd8);
    chk("fill_full_logic", 32'(full_logic), 32'd1);
    chk("fill_empty_logic", 32'(empty_logic), 32'd0);
    chk("fill_ovr", 32'(ovr_err), 32'd0);
    chk("fill_full_arit", 32'(full_arit), 32'd0);
    w_en = 1'b1; addr_w = 4'd3; d_in = 32'hABCD_0003;
    tick();
    idle();
    chk("ovr_flag", 32'(ovr_err), 32'd1);
    chk("ovr_cnt_logic", 32'(cnt_logic), 32'd8);
    chk("ovr_w_ack", 32'(w_ack), 32'd1);
    r_en = 1'b1; addr_r = 4'd3;
    tick();
    idle();
    chk("rd3_d_out", d_out, 32'hABCD_0003);
    chk("rd3_cnt_logic", 32'(cnt_logic), 32'd7);
    chk("rd3_full_logic", 32'(full_logic), 32'd0);
    tick();
    chk("ovr_sticky", 32'(ovr_err), 32'd1);

    // Underrun on empty address 12
    r_en = 1'b1; addr_r = 4'd12;
    tick();
    idle();
    chk("udr_d_out", d_out, 32'd0);
    chk("udr_d_valid", 32'(d_valid), 32'd0);
    chk("udr_flag", 32'(udr_err), 32'd1);
    chk("udr_cnt_arit", 32'(cnt_arit), 32'd0);

    // Reset clears flags and counts
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_errs", 32'({ovr_err, udr_err}), 32'd0);
    chk("rst2_cnt_logic", 32'(cnt_logic), 32'd0);

    // Same-cycle write/read to address 2
    w_en = 1'b1; addr_w = 4'd2; d_in = 32'h5;
    r_en = 1'b1; addr_r = 4'd2;
    tick();
    idle();
    chk("wf_d_out", d_out, 32'h5);
    chk("wf_d_valid", 32'(d_valid), 32'd1);
    chk("wf_cnt_logic", 32'(cnt_logic), 32'd0);
    chk("wf_errs", 32'({ovr_err, udr_err}), 32'd0);

    // Write 0, then write 1 while reading 0: count nets to 1
    w_en = 1'b1; addr_w = 4'd0; d_in = 32'h1111_0000;
    tick();
    chk("w0_cnt_logic", 32'(cnt_logic), 32'd1);
    w_en = 1'b1; addr_w = 4'd1; d_in = 32'h2222_0001;
    r_en = 1'b1; addr_r = 4'd0;
    tick();
    idle();
    chk("mix_d_out", d_out, 32'h1111_0000);
    chk("mix_cnt_logic", 32'(cnt_logic), 32'd1);
    chk("mix_errs", 32'({ovr_err, udr_err}), 32'd0);

    // Reset the cycle after a write to 8
    w_en = 1'b1; addr_w = 4'd8; d_in = 32'h8888_8888;
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("inflight_w_ack", 32'(w_ack), 32'd0);
    tick();
    rst = 1'b0;
    chk("inflight_cnt_arit", 32'(cnt_arit), 32'd0);
    chk("inflight_empty_arit", 32'(empty_arit), 32'd1);
    chk("inflight_w_ack2", 32'(w_ack), 32'd0);
    r_en = 1'b1; addr_r = 4'd8;
    tick();
    idle();
    chk("rd8_udr", 32'(udr_err), 32'd1);
    chk("rd8_d_valid", 32'(d_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_ram.md
RESULT_RAM -- requirements
Module: result_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 4, address width (16 words, two 8-word banks).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port w_en  input  1  write request from the control unit.
REQ-006 SHALL have port addr_w  input  ADDR_W  write address; bit 3 = 1 selects arith bank (8-15), 0 selects logic bank (0-7).
REQ-007 SHALL have port d_in  input  DATA_W  ALU result to store.
REQ-008 SHALL have port r_en  input  1  read request from the control unit.
REQ-009 SHALL have port addr_r  input  ADDR_W  read address, same bank mapping as addr_w.
REQ-010 SHALL have port d_out  output  DATA_W  registered read data.
REQ-011 SHALL have port d_valid  output  1  one-cycle pulse qualifying d_out.
REQ-012 SHALL have port w_ack  output  1  one-cycle pulse confirming a write.
REQ-013 SHALL have port cnt_arit, cnt_logic  output  4 each  occupied-entry count per bank (0-8).
REQ-014 SHALL have port full_arit, full_logic, empty_arit, empty_logic  output  1 each  bank status.
REQ-015 SHALL have port ovr_err, udr_err  output  1 each  sticky overwrite / underrun flags.

Function
REQ-016 Storage SHALL be 16 x DATA_W words plus one valid bit per word.
REQ-017 On w_en, SHALL write d_in to mem[addr_w], set its valid bit, and pulse w_ack in the following cycle (latency 1).
REQ-018 Write to an already-valid word SHALL overwrite it, leave the count unchanged, and set ovr_err.
REQ-019 On r_en with mem[addr_r] valid, SHALL drive d_out = mem[addr_r] and d_valid = 1 in the next cycle, and clear the valid bit (read consumes).
REQ-020 On r_en with mem[addr_r] invalid, SHALL drive d_out = 0, keep d_valid = 0, and set udr_err.
REQ-021 d_out SHALL hold its last value while d_valid = 0, except that it is forced to 0 by REQ-020.
REQ-022 Same-cycle w_en and r_en to the same address SHALL be write-first: d_out = d_in, d_valid = 1, valid bit ends 0, count unchanged, no error flag.
REQ-023 Same-cycle w_en and r_en to different addresses SHALL both complete, with each bank count updated independently, including a +1 and a -1 in the same bank netting to 0.
REQ-024 Each bank count SHALL equal the popcount of that bank's valid bits and SHALL never wrap past 8 or below 0.
REQ-025 full_x SHALL be 1 iff cnt_x = 8, and empty_x SHALL be 1 iff cnt_x = 0; both SHALL be registered and consistent with the count in the same cycle.
REQ-026 ovr_err and udr_err SHALL stay set until rst.

Reset
REQ-027 While rst = 1, SHALL clear all valid bits and set d_out = 0, d_valid = 0, w_ack = 0, counts = 0, empty_x = 1, full_x = 0, and both error flags = 0.
REQ-028 Memory contents need not be cleared; requests arriving while rst = 1 SHALL be ignored, including requests already in flight, which SHALL produce no w_ack or d_valid after reset.

Structure
REQ-029 Package ram_pkg SHALL hold DATA_W, ADDR_W, BANK_WORDS = 8, ARIT_BASE = 8 and LOGIC_BASE = 0.
REQ-030 Sub-module bank_tracker (8 valid bits, set/clear ports, count, full, empty) SHALL be instantiated once per bank.

Verification
REQ-031 The bench SHALL cover: reset -> counts 0, empty_x 1, d_valid 0, errors 0.
REQ-032 The bench SHALL cover: write 0xDEAD_BEEF to address 9, then read 9 -> w_ack at cycle +1; d_out = 0xDEADBEEF and d_valid at the read cycle +1; cnt_arit goes 1 then 0.
REQ-033 The bench SHALL cover: writes to addresses 0-7 -> full_logic = 1, cnt_logic = 8; then a rewrite of address 3 -> ovr_err = 1 and cnt_logic stays 8.
REQ-034 The bench SHALL cover: read of empty address 12 -> d_out = 0, d_valid = 0, udr_err = 1.
REQ-035 The bench SHALL cover: same-cycle write 0x5 and read to address 2 -> d_out = 0x5, d_valid = 1, cnt_logic unchanged, no errors.
REQ-036 The bench SHALL cover: rst asserted the cycle after a write to address 8 -> no w_ack, cnt_arit = 0, and a later read of 8 sets udr_err.
